instr_fetch_unit: RTL and testbench

- Upstream neighbour of control_unit in the multicycle MIPS CPU.
- Owns the program counter and fetches each instruction from instruction memory through a req/ack handshake.
- Presents the instruction to control_unit for exactly one EXEC cycle, then computes the next PC from control_unit's pc_control.
- Detects imem timeouts and misaligned targets, then halts in a sticky fault state.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS fetch unit: owns the PC, fetches over req/ack,
// hands one instruction per EXEC cycle to control_unit.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pc_control,
  input  logic [31:0] jr_target,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_FAULT
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_cnt;
  logic [1:0]  r_fault_code;
  logic [31:0] r_fault_addr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic [31:0] w_br_off;
  logic        w_misaligned;
  logic        w_timeout;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_off     = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_misaligned = |w_next_pc[1:0];
  assign w_timeout    = (r_cnt == LP_TO_LAST);

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (pc_control)
      4'b0001: w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      4'b0010: w_next_pc = jr_target;
      4'b0011: w_next_pc = w_pc_plus4 + w_br_off;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_ack)       w_next_state = S_EXEC;
        else if (w_timeout) w_next_state = S_FAULT;
      end
      S_EXEC: begin
        if (w_misaligned) w_next_state = S_FAULT;
        else              w_next_state = S_FETCH;
      end
      default: w_next_state = S_FAULT;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == S_FETCH) && !rst;
    instr_valid = (r_state == S_EXEC);
    fetch_fault = (r_state == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0;
      r_cnt        <= 8'h0;
      r_fault_code <= 2'b00;
      r_fault_addr <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_cnt   <= 8'h0;
          end else if (w_timeout) begin
            r_fault_code <= 2'b01;
            r_fault_addr <= r_pc;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          if (w_misaligned) begin
            r_fault_code <= 2'b10;
            r_fault_addr <= w_next_pc;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instruction = r_instr;
  assign fault_code  = r_fault_code;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed literals plus random traffic
// against a cycle-level behavioural model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  pc_control = 0;
  logic [31:0] jr_target = 0;
  logic        imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr;

  instr_fetch_unit #(.RESET_PC(RPC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc_control(pc_control),
    .jr_target(jr_target), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault), .fault_code(fault_code),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Model: phase 0 = waiting for instruction, 1 = executing, 2 = halted
  int          m_ph = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_ins = 0;
  int          m_wait = 0;
  logic [1:0]  m_code = 0;
  logic [31:0] m_faddr = 0;

  function automatic logic [31:0] target(input logic [3:0] c,
                                         input logic [31:0] p,
                                         input logic [31:0] ins,
                                         input logic [31:0] jr);
    logic [31:0] seq;
    int signed   imm;
    seq = p + 4;
    imm = int'($signed(ins[15:0]));
    if (c == 1) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (c == 2) return jr;
    if (c == 3) return seq + 32'(imm * 4);
    return seq;
  endfunction

  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_ph = 0; m_pc = RPC; m_ins = 0; m_wait = 0;
      m_code = 0; m_faddr = 0;
    end else if (m_ph == 0) begin
      if (imem_ack) begin
        m_ins = imem_rdata; m_wait = 0; m_ph = 1;
      end else begin
        m_wait++;
        if (m_wait >= TO) begin
          m_ph = 2; m_code = 2'b01; m_faddr = m_pc;
        end
      end
    end else if (m_ph == 1) begin
      t = target(pc_control, m_pc, m_ins, jr_target);
      if (t % 4 != 0) begin
        m_ph = 2; m_code = 2'b10; m_faddr = t;
      end else begin
        m_pc = t; m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("imem_req", 32'(imem_req), 32'(m_ph == 0 && !rst));
      check("imem_addr", imem_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_ph == 1));
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 4);
      check("instruction", instruction, m_ins);
      check("fetch_fault", 32'(fetch_fault), 32'(m_ph == 2));
      check("fault_code", 32'(fault_code), 32'(m_code));
      check("fault_addr", fault_addr, m_faddr);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; imem_ack = 0; pc_control = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic run_instr(input int waits, input logic [31:0] w,
                           input logic [3:0] c, input logic [31:0] jr);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 0; cyc();
    end
    imem_ack = 1; imem_rdata = w; cyc();
    imem_ack = 0; pc_control = c; jr_target = jr; cyc();
    pc_control = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1;

    imem_ack = 1; imem_rdata = 32'h2008_0005;
    #3;
    check("lit_addr0", imem_addr, 32'h0);
    check("lit_req0", 32'(imem_req), 32'h1);
    cyc();
    #3;
    check("lit_valid", 32'(instr_valid), 32'h1);
    check("lit_instr", instruction, 32'h2008_0005);
    imem_ack = 0; pc_control = 0;
    cyc();
    #3;
    check("lit_pc4", pc, 32'h4);
    check("lit_valid_off", 32'(instr_valid), 32'h0);

    run_instr(0, 32'h0, 2, 32'h1000_0040);
    run_instr(0, 32'h0800_0010, 1, 0);
    #3 check("lit_jump", pc, 32'h1000_0040);

    run_instr(0, 32'h0, 2, 32'h0000_0100);
    run_instr(1, 32'h1000_FFFE, 3, 0);
    #3 check("lit_branch", pc, 32'h0000_00FC);

    do_reset();
    run_instr(0, 32'h1000_FFFE, 3, 0);
    #3 check("lit_br_wrap", pc, 32'hFFFF_FFFC);
    run_instr(0, 32'h0, 0, 0);
    #3 check("lit_pc_wrap", pc, 32'h0);
    check("lit_wrap_nofault", 32'(fetch_fault), 32'h0);

    run_instr(0, 32'h0, 2, 32'h0000_0202);
    #3;
    check("lit_jr_fault", 32'(fetch_fault), 32'h1);
    check("lit_jr_code", 32'(fault_code), 32'h2);
    check("lit_jr_addr", fault_addr, 32'h0000_0202);
    check("lit_jr_pc", pc, 32'h0);
    imem_ack = 1; cyc(); cyc();
    #3 check("lit_jr_noreq", 32'(imem_req), 32'h0);

    do_reset();
    cyc(); cyc(); cyc();
    #3 check("lit_to_3", 32'(fetch_fault), 32'h0);
    cyc();
    #3;
    check("lit_to_4", 32'(fetch_fault), 32'h1);
    check("lit_to_code", 32'(fault_code), 32'h1);

    do_reset();
    run_instr(2, 32'h0, 0, 0);
    #3;
    check("lit_ack3_pc", pc, 32'h4);
    check("lit_ack3_nofault", 32'(fetch_fault), 32'h0);

    run_instr(0, 32'h0, 2, 32'h40);
    imem_ack = 0; cyc();
    rst = 1; imem_ack = 1; cyc();
    rst = 0; imem_ack = 0;
    #3;
    check("lit_rst_pc", pc, RPC);
    check("lit_rst_nofault", 32'(fetch_fault), 32'h0);
    check("lit_rst_req", 32'(imem_req), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0) ||
            (m_ph == 2 && $urandom_range(0, 3) == 0);
      imem_ack = $urandom_range(0, 1) == 1;
      imem_rdata = $urandom;
      pc_control = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                               : 4'($urandom_range(0, 3));
      jr_target = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
    end
    @(negedge clk);
    rst = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
